// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: sequencer state encodings.
// S_DONE keeps its code so sibling serial-arithmetic sequencers can share it.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_serial_adder_add2_cell.sv
// Combinational 2-bit full-adder slice: {Cout,Sum} = A + B + Cin.
module add2_cell (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin,
  output logic [1:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {2'b00, Cin};

endmodule

// File: rtl/digit_serial_adder.sv
// Sequencer adding two WIDTH-bit operands two bits per clock through one add2_cell,
// with the slice carry fed back through a register and a start/busy/done handshake.
module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  import digit_serial_adder_pkg::*;

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW     = (WIDTH > 2) ? WIDTH - 2 : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [SW-1:0]    sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_next;

  add2_cell u_cell (
    .A    (a_sh[1:0]),
    .B    (b_sh[1:0]),
    .Cin  (carry),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // Only the upper WIDTH-2 partial-sum bits are kept; the lowest digit shifts out
  // on the last step straight into the result register.
  if (WIDTH > 2) begin : g_wide
    assign sum_next = {slice_sum, sum_sh};
  end else begin : g_narrow
    assign sum_next = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= S_RUN;
            busy   <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 2;
          b_sh   <= b_sh >> 2;
          sum_sh <= sum_next[WIDTH-1:WIDTH-SW];
          carry  <= slice_cout;
          if (cnt == LAST) begin
            sum   <= sum_next;
            cout  <= slice_cout;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=8): directed handshake cases plus
// a random regression checked against plain a+b+cin arithmetic.
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int         nVectors = 0;
  int         nFail = 0;
  int         doneCount = 0;
  int         cycle = 0;
  logic [8:0] expq[$];

  digit_serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for the DUT to be able to accept, then issues one request and optionally
  // records the arithmetically expected {cout,sum}. Entered and left at a negedge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                               input bit push);
    int guard = 0;
    while (busy === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("ready_timeout", 32'd1, 32'd0);
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    if (push) expq.push_back(9'(int'(av) + int'(bv) + int'(cv)));
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic waitDone(input string name);
    int guard = 0;
    while (done !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) checkOutput(name, 32'd0, 32'd1);
  endtask

  // Monitor: every done pulse is compared against the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        doneCount++;
        if (expq.size() == 0) begin
          checkOutput("unexpected_done", {23'd0, cout, sum}, 32'h1ff);
        end else begin
          checkOutput("result", {23'd0, cout, sum}, {23'd0, expq.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int snap;
    int t0;

    // Reset held for two edges, then the first released cycle must be idle.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_sum", {24'd0, sum}, 32'h00);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_done", {31'd0, done}, 32'd0);

    // Full carry ripple; busy must last exactly DIGITS cycles before done.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", n, 32'd4);
    checkOutput("done_after_busy", {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);

    applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b1);
    waitDone("done_timeout_a5");
    @(negedge clk);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    waitDone("done_timeout_00");
    repeat (2) @(negedge clk);

    // A start arriving during RUN is ignored.
    snap = doneCount;
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b1);
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("single_done", doneCount - snap, 32'd1);

    // Start held through the done cycle chains a second add back to back.
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
    a = 8'h7F;
    b = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    waitDone("done_timeout_chain1");
    t0 = cycle;
    expq.push_back(9'h080);
    @(negedge clk);
    start = 1'b0;
    checkOutput("chain_busy", {31'd0, busy}, 32'd1);
    waitDone("done_timeout_chain2");
    checkOutput("chain_spacing", cycle - t0, 32'd5);
    repeat (3) @(negedge clk);

    // Reset on the third RUN cycle aborts without a done pulse.
    snap = doneCount;
    applyStimulus(8'hC3, 8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_sum", {24'd0, sum}, 32'h00);
    checkOutput("abort_cout", {31'd0, cout}, 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("abort_no_done", doneCount - snap, 32'd0);

    // Random regression with random gaps, including back-to-back requests.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
